// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: two requesters (m0 = pipeline MEM stage, m1 = loader/debug)
// share one memory port. Round-robin on ties, one transaction in flight,
// per-transaction timeout after MAX_WAIT busy cycles without the matching ready.
module dmem_arbiter #(
  parameter int MAX_WAIT = 15
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_m0_req,
  input  logic        i_m0_we,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [1:0]  i_m0_size,
  output logic        o_m0_gnt,
  output logic        o_m0_done,
  output logic [31:0] o_m0_rdata,
  output logic        o_m0_err,
  input  logic        i_m1_req,
  input  logic        i_m1_we,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic [1:0]  i_m1_size,
  output logic        o_m1_gnt,
  output logic        o_m1_done,
  output logic [31:0] o_m1_rdata,
  output logic        o_m1_err,
  output logic        o_mem_re,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [1:0]  o_mem_size,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_rd_ready,
  input  logic        i_mem_wr_ready
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;
  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  logic        state_q, state_d;
  logic        lg_q, lg_d;          // last granted requester
  logic        owner_q, owner_d;    // requester of the transaction in flight
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic        err0_q, err0_d, err1_q, err1_d;

  logic        win;
  logic        ready_hit;
  logic        fin;
  logic        fin_err;
  logic [31:0] fin_data;
  logic [7:0]  cnt_inc;

  // Next-state: arbitration in IDLE, completion/timeout tracking in BUSY
  always_comb begin
    state_d  = state_q;
    lg_d     = lg_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    err0_d   = err0_q;
    err1_d   = err1_q;
    fin      = 1'b0;
    fin_err  = 1'b0;
    fin_data = 32'd0;
    cnt_inc  = cnt_q + 8'd1;
    // On a tie the requester that did not win last time goes; otherwise whoever asks
    win       = (i_m0_req && i_m1_req) ? ~lg_q : i_m1_req;
    ready_hit = we_q ? i_mem_wr_ready : i_mem_rd_ready;

    if (state_q == ST_IDLE) begin
      if (i_m0_req || i_m1_req) begin
        state_d = ST_BUSY;
        lg_d    = win;
        owner_d = win;
        cnt_d   = 8'd0;
        we_d    = win ? i_m1_we    : i_m0_we;
        addr_d  = win ? i_m1_addr  : i_m0_addr;
        wdata_d = win ? i_m1_wdata : i_m0_wdata;
        size_d  = win ? i_m1_size  : i_m0_size;
        gnt0_d  = ~win;
        gnt1_d  = win;
      end
    end else begin
      if (ready_hit) begin
        fin      = 1'b1;
        fin_data = we_q ? 32'd0 : i_mem_rdata;
      end else if (cnt_inc == MAX_W) begin
        fin     = 1'b1;
        fin_err = 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
      if (fin) begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
        if (owner_q) begin
          done1_d  = 1'b1;
          rdata1_d = fin_data;
          err1_d   = fin_err;
        end else begin
          done0_d  = 1'b1;
          rdata0_d = fin_data;
          err0_d   = fin_err;
        end
      end
    end
  end

  // State registers; reset leaves LG=1 so m0 wins the first tie
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= ST_IDLE;
      lg_q     <= 1'b1;
      owner_q  <= 1'b0;
      cnt_q    <= 8'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      size_q   <= 2'd0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lg_q     <= lg_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

  // Strobes come only from registered state so an async reset drops them at once
  assign o_mem_re    = (state_q == ST_BUSY) & ~we_q;
  assign o_mem_we    = (state_q == ST_BUSY) &  we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_size  = size_q;

  assign o_m0_gnt   = gnt0_q;
  assign o_m1_gnt   = gnt1_q;
  assign o_m0_done  = done0_q;
  assign o_m1_done  = done1_q;
  assign o_m0_rdata = rdata0_q;
  assign o_m1_rdata = rdata1_q;
  assign o_m0_err   = err0_q;
  assign o_m1_err   = err1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 15;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [1:0]  m0_size = 0, m1_size = 0;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata = 0;
  logic        rd_ready = 0, wr_ready = 0;

  int total = 0;
  int bad = 0;

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .i_m0_size(m0_size), .o_m0_gnt(m0_gnt), .o_m0_done(m0_done), .o_m0_rdata(m0_rdata),
    .o_m0_err(m0_err),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .i_m1_size(m1_size), .o_m1_gnt(m1_gnt), .o_m1_done(m1_done), .o_m1_rdata(m1_rdata),
    .o_m1_err(m1_err),
    .o_mem_re(mem_re), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_size(mem_size), .i_mem_rdata(mem_rdata), .i_mem_rd_ready(rd_ready),
    .i_mem_wr_ready(wr_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m1_req = 0; rd_ready = 0; wr_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rstn = 0;
    tick(); tick();
    i_rstn = 1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, mem_re, mem_we} !== 8'b0 ||
        m0_rdata !== 0 || m1_rdata !== 0 || mem_addr !== 0 || mem_wdata !== 0 || mem_size !== 0) begin
      bad++;
      $display("FAIL reset_state: gnt/done/err/strobe=%b rd0=%h rd1=%h addr=%h, required all zero",
               {m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, mem_re, mem_we}, m0_rdata, m1_rdata, mem_addr);
    end
  endtask

  // m0 read of 0x10, ready two cycles after the strobe rises
  task automatic test_read();
    int re_cnt = 0, gnt_cnt = 0, done_cnt = 0;
    logic [31:0] rd = 0; logic er = 1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h10; m0_size = 2'd2;
    mem_rdata = 32'hDEADBEEF;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (m0_gnt) begin gnt_cnt++; m0_req = 0; end
      if (mem_re) re_cnt++;
      if (m0_done) begin done_cnt++; rd = m0_rdata; er = m0_err; end
      rd_ready = (re_cnt == 3) && mem_re;
    end
    idle_inputs();
    total++;
    if (gnt_cnt != 1 || re_cnt != 3 || done_cnt != 1) begin
      bad++; $display("FAIL read_counts: gnt=%0d re=%0d done=%0d, required 1/3/1", gnt_cnt, re_cnt, done_cnt);
    end
    total++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      bad++; $display("FAIL read_data: rdata0=%h err0=%b, required deadbeef/0", rd, er);
    end
  endtask

  // Live address changes during BUSY must not reach the memory port
  task automatic test_addr_hold();
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    tick();
    m0_addr = 32'h30;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if (mem_addr !== 32'h10 || mem_re !== 1'b1) begin
        bad++; $display("FAIL addr_hold: addr=%h re=%b, required 00000010/1", mem_addr, mem_re);
      end
    end
    m0_req = 0; rd_ready = 1;
    tick(); rd_ready = 0; tick();
  endtask

  // m1 write never acknowledged: timeout after MAX_WAIT strobe cycles
  task automatic test_timeout();
    int we_cnt = 0, done_cnt = 0;
    logic er = 0; logic [31:0] rd = 32'hFFFF_FFFF;
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h55;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (m1_gnt) m1_req = 0;
      if (mem_we) we_cnt++;
      if (m1_done) begin done_cnt++; er = m1_err; rd = m1_rdata; end
    end
    total++;
    if (we_cnt != MAX_WAIT || done_cnt != 1) begin
      bad++; $display("FAIL timeout_len: we_cycles=%0d done=%0d, required %0d/1", we_cnt, done_cnt, MAX_WAIT);
    end
    total++;
    if (er !== 1'b1 || rd !== 32'd0) begin
      bad++; $display("FAIL timeout_flag: err1=%b rdata1=%h, required 1/0", er, rd);
    end
  endtask

  // Read-ready during a write is ignored; write-ready later completes it
  task automatic test_wrong_ready();
    int done_cnt = 0; logic er = 1;
    m0_req = 1; m0_we = 1; m0_addr = 32'h44; m0_wdata = 32'h1234;
    tick(); m0_req = 0;
    rd_ready = 1; tick(); rd_ready = 0;
    tick();
    total++;
    if (mem_we !== 1'b1 || m0_done !== 1'b0) begin
      bad++; $display("FAIL wrong_ready: we=%b done0=%b, required 1/0", mem_we, m0_done);
    end
    wr_ready = 1;
    for (int c = 0; c < 5; c++) begin
      tick(); wr_ready = 0;
      if (m0_done) begin done_cnt++; er = m0_err; end
    end
    total++;
    if (done_cnt != 1 || er !== 1'b0) begin
      bad++; $display("FAIL write_done: done0=%0d err0=%b, required 1/0", done_cnt, er);
    end
  endtask

  // Both requesting from reset: grants alternate, never overlapping
  task automatic test_round_robin();
    int order[$];
    int ovl = 0;
    do_reset();
    m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0; rd_ready = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if ((m0_gnt && m1_gnt) || (mem_re && mem_we) || (m0_done && m1_done) ||
          ((m0_gnt || m1_gnt) && (m0_done || m1_done))) ovl++;
      if (m0_gnt) order.push_back(0);
      if (m1_gnt) order.push_back(1);
    end
    idle_inputs(); tick(); tick();
    total++;
    if (ovl != 0 || order.size() < 8) begin
      bad++; $display("FAIL rr_overlap: overlaps=%0d grants=%0d, required 0/>=8", ovl, order.size());
    end
    for (int i = 0; i < order.size(); i++) begin
      total++;
      if (order[i] != (i % 2)) begin
        bad++; $display("FAIL rr_order: grant %0d went to m%0d, required m%0d", i, order[i], i % 2);
      end
    end
  endtask

  // Async reset mid-read: strobe drops without an edge, no done, m0 wins next tie
  task automatic test_reset_busy();
    int done_cnt = 0;
    m1_req = 1; m1_we = 0; tick(); m1_req = 0;   // make LG point at m1's opponent
    rd_ready = 1; tick(); rd_ready = 0; tick();
    m0_req = 1; m0_we = 0; m0_addr = 32'h80;
    tick(); m0_req = 0; tick();
    #2 i_rstn = 0;
    #1;
    total++;
    if (mem_re !== 1'b0 || mem_addr !== 32'd0) begin
      bad++; $display("FAIL reset_async: re=%b addr=%h, required 0/0", mem_re, mem_addr);
    end
    rd_ready = 1;
    for (int c = 0; c < 3; c++) begin tick(); if (m0_done || m1_done) done_cnt++; end
    i_rstn = 1; rd_ready = 0;
    tick();
    if (m0_done || m1_done) done_cnt++;
    total++;
    if (done_cnt != 0 || mem_re !== 1'b0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL reset_nodone: dones=%0d re=%b we=%b, required 0/0/0", done_cnt, mem_re, mem_we);
    end
    m0_req = 1; m1_req = 1; tick();
    total++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      bad++; $display("FAIL reset_tie: gnt0=%b gnt1=%b, required 1/0", m0_gnt, m1_gnt);
    end
    idle_inputs(); rd_ready = 1; tick(); rd_ready = 0; tick();
  endtask

  // Randomized traffic against a transaction-level model
  task automatic test_random(input int cycles, input int rdy_div);
    bit busy = 0, owner = 0, lastg = 1, twe = 0;
    int waited = 0;
    logic [31:0] taddr = 0, twd = 0;
    logic [31:0] e_rd[2] = '{32'd0, 32'd0};
    bit e_err[2] = '{1'b0, 1'b0};
    bit e_gnt[2], e_done[2];
    bit rq[2]; bit wq[2]; logic [31:0] aq[2]; logic [31:0] dq[2];
    int w;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      rq[0] = ($urandom_range(0, 2) == 0); rq[1] = ($urandom_range(0, 2) == 0);
      wq[0] = $urandom_range(0, 1); wq[1] = $urandom_range(0, 1);
      aq[0] = $urandom; aq[1] = $urandom; dq[0] = $urandom; dq[1] = $urandom;
      m0_req = rq[0]; m0_we = wq[0]; m0_addr = aq[0]; m0_wdata = dq[0];
      m1_req = rq[1]; m1_we = wq[1]; m1_addr = aq[1]; m1_wdata = dq[1];
      rd_ready = ($urandom_range(0, rdy_div) == 0);
      wr_ready = ($urandom_range(0, rdy_div) == 0);
      mem_rdata = $urandom;
      e_gnt = '{1'b0, 1'b0}; e_done = '{1'b0, 1'b0};
      if (!busy) begin
        if (rq[0] || rq[1]) begin
          if (rq[0] && rq[1]) w = (lastg == 1) ? 0 : 1;
          else w = rq[0] ? 0 : 1;
          busy = 1; owner = w[0]; lastg = w[0]; waited = 0;
          twe = wq[w]; taddr = aq[w]; twd = dq[w];
          e_gnt[w] = 1;
        end
      end else if ((twe && wr_ready) || (!twe && rd_ready)) begin
        busy = 0; e_done[owner] = 1; e_err[owner] = 0;
        e_rd[owner] = twe ? 32'd0 : mem_rdata;
      end else begin
        waited++;
        if (waited == MAX_WAIT) begin
          busy = 0; e_done[owner] = 1; e_err[owner] = 1; e_rd[owner] = 32'd0;
        end
      end
      tick();
      total++;
      if ({m0_gnt, m1_gnt, m0_done, m1_done} !== {e_gnt[0], e_gnt[1], e_done[0], e_done[1]}) begin
        bad++; $display("FAIL rand_handshake c%0d: gnt/done=%b, required %b", c,
                        {m0_gnt, m1_gnt, m0_done, m1_done}, {e_gnt[0], e_gnt[1], e_done[0], e_done[1]});
      end
      total++;
      if (m0_rdata !== e_rd[0] || m1_rdata !== e_rd[1] || m0_err !== e_err[0] || m1_err !== e_err[1]) begin
        bad++; $display("FAIL rand_resp c%0d: rd0=%h e0=%b rd1=%h e1=%b, required %h %b %h %b", c,
                        m0_rdata, m0_err, m1_rdata, m1_err, e_rd[0], e_err[0], e_rd[1], e_err[1]);
      end
      total++;
      if (mem_re !== (busy && !twe) || mem_we !== (busy && twe) ||
          (busy && (mem_addr !== taddr || mem_wdata !== twd))) begin
        bad++; $display("FAIL rand_mem c%0d: re=%b we=%b addr=%h wd=%h, required %b %b %h %h", c,
                        mem_re, mem_we, mem_addr, mem_wdata, busy && !twe, busy && twe, taddr, twd);
      end
    end
    idle_inputs();
    for (int c = 0; c < MAX_WAIT + 3; c++) tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_addr_hold();
    test_timeout();
    test_wrong_ready();
    test_round_robin();
    test_reset_busy();
    test_random(600, 2);
    test_random(600, 24);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 15: BUSY cycles allowed before timeout abort (range 1..255).
REQ-002 The block SHALL have port i_clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_rstn  in  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have ports i_mN_req  in  1, for N=0 (pipeline MEM stage) and N=1 (UART loader/debug): transaction request.
REQ-005 The block SHALL have ports i_mN_we  in  1: 1=write, 0=read.
REQ-006 The block SHALL have ports i_mN_addr  in  32: byte address.
REQ-007 The block SHALL have ports i_mN_wdata  in  32: write data.
REQ-008 The block SHALL have ports i_mN_size  in  2: BYTE/HWORD/WORD code, passed through unchanged.
REQ-009 The block SHALL have ports o_mN_gnt  out  1: one-cycle pulse, request accepted.
REQ-010 The block SHALL have ports o_mN_done  out  1: one-cycle pulse, transaction finished.
REQ-011 The block SHALL have ports o_mN_rdata  out  32: read data, valid with done.
REQ-012 The block SHALL have ports o_mN_err  out  1: timeout flag, valid with done.
REQ-013 The block SHALL have ports o_mem_re, o_mem_we  out  1: memory strobes.
REQ-014 The block SHALL have ports o_mem_addr  out  32, o_mem_wdata  out  32, o_mem_size  out  2: memory command.
REQ-015 The block SHALL have ports i_mem_rdata  in  32, i_mem_rd_ready  in  1, i_mem_wr_ready  in  1: memory response.

Function
REQ-016 The FSM SHALL have two states, IDLE and BUSY, plus a 1-bit last-grant pointer LG and an 8-bit wait counter.
REQ-017 In IDLE with exactly one requester asserting req, that requester SHALL be granted at the next edge.
REQ-018 In IDLE with both requesters asserting req, the one not equal to LG SHALL be granted (round-robin), and LG SHALL be updated to the winner.
REQ-019 On grant: latch we/addr/wdata/size of the winner, pulse o_mN_gnt for one cycle, clear counter, enter BUSY; all on the same edge.
REQ-020 In BUSY, o_mem_re = ~we_latched and o_mem_we = we_latched; they SHALL be driven from latched registers only, and both SHALL be 0 in IDLE.
REQ-021 o_mem_addr/wdata/size SHALL hold latched values throughout BUSY, independent of live requester inputs.
REQ-022 In BUSY, the matching ready (rd_ready for read, wr_ready for write) sampled high at an edge SHALL end the transaction at that edge: capture i_mem_rdata (reads; writes capture 0), pulse o_mN_done next cycle with err=0, return to IDLE.
REQ-023 The non-matching ready signal SHALL be ignored.
REQ-024 The counter SHALL increment each BUSY cycle without ready; when it equals MAX_WAIT, the transaction SHALL abort: rdata=0, done pulse with err=1, return to IDLE.
REQ-025 o_mN_rdata and o_mN_err SHALL hold their values until that requester's next done.
REQ-026 Minimum latency SHALL be req sampled at edge E -> gnt and strobe high in cycle E+1 -> done in cycle E+2 if ready is high in cycle E+1.
REQ-027 A new grant SHALL be possible at the same edge that returns the FSM to IDLE +1, i.e. one idle cycle between transactions.
REQ-028 req deasserted before gnt SHALL withdraw the request; no memory access SHALL occur for it.
REQ-029 req held during BUSY SHALL NOT be re-granted until the FSM is in IDLE.
REQ-030 The gnt and done of the two requesters SHALL never both be high for the same N in a cycle, and never for both N simultaneously.

Reset
REQ-031 Assertion of i_rstn low SHALL immediately (asynchronously) clear state to IDLE, LG=1 (so m0 wins the first tie), counter=0, all gnt/done/err/strobes=0, rdata/addr/wdata=0, size=0.
REQ-032 Reset asserted mid-BUSY SHALL drop the memory strobes without a done pulse; requesters SHALL re-request after reset.

Verification
REQ-033 A bench SHALL cover this scenario: m0 read addr 0x10, rd_ready high 2 cycles after strobe, rdata 0xDEADBEEF -> gnt0 once, o_mem_re high 3 cycles, done0 with rdata0=0xDEADBEEF, err0=0.
REQ-034 A bench SHALL cover this scenario: both req from reset, continuously -> grants alternate m0,m1,m0,m1; no cycle with both strobes or both gnt.
REQ-035 A bench SHALL cover this scenario: m1 write 0x55 to 0x20, wr_ready never high, MAX_WAIT=15 -> strobe high exactly 15 cycles, done1 with err1=1, rdata1=0.
REQ-036 A bench SHALL cover this scenario: m0 write, rd_ready pulsed high while wr_ready low -> transaction continues; wr_ready high later -> done0, err0=0.
REQ-037 A bench SHALL cover this scenario: i_rstn low during BUSY read -> o_mem_re falls without a clock edge, no done; after release, IDLE, next tie grants m0.
REQ-038 A bench SHALL cover this scenario: m0 changes addr from 0x10 to 0x30 during BUSY -> o_mem_addr stays 0x10.
